lab1_count_ctrl: RTL and testbench

LAB1_COUNT_CTRL -- requirements
Module: lab1_count_ctrl

---
 rtl/lab1_count_ctrl.sv | 133 +++++++++++++
 tb/tb_lab1_count_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lab1_count_ctrl.sv
// Lab counter control: synchronized, debounced start/pause and load buttons drive a 4-state FSM plus tick prescaler.
// Button event 2+DEB_CYCLES cycles after press, FSM responds next edge; all outputs from registers, no backpressure.
module lab1_count_ctrl_deb #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btnN,
  output logic pressEvt
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          released;
  logic [CW-1:0] stableCnt;

  // Count cycles where the level disagrees with the debounced state; flip after DEB_CYCLES of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      released  <= 1'b1;
      stableCnt <= '0;
      pressEvt  <= 1'b0;
    end else begin
      sync1    <= btnN;
      sync2    <= sync1;
      pressEvt <= 1'b0;
      if (sync2 == released) begin
        stableCnt <= '0;
      end else if (stableCnt == CNT_LAST) begin
        stableCnt <= '0;
        released  <= ~released;
        pressEvt  <= released;
      end else begin
        stableCnt <= stableCnt + 1'b1;
      end
    end
  end
endmodule

module lab1_count_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       load_n,
  input  logic       run_n,
  input  logic [9:0] sw,
  output logic       cnt_en,
  output logic       cnt_load,
  output logic [9:0] load_data,
  output logic       running,
  output logic [1:0] state
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LOAD  = 2'b11
  } ctrlState_t;

  ctrlState_t    curState, nextState;
  ctrlState_t    savedState, nextSaved;
  logic [9:0]    loadReg, nextLoad;
  logic [PW-1:0] prescaler, nextPrescaler;
  logic          loadEvt;
  logic          runEvt;

  lab1_count_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) loadDeb (
    .clk      (CLOCK_50),
    .reset    (reset),
    .btnN     (load_n),
    .pressEvt (loadEvt)
  );

  lab1_count_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) runDeb (
    .clk      (CLOCK_50),
    .reset    (reset),
    .btnN     (run_n),
    .pressEvt (runEvt)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      curState   <= IDLE;
      savedState <= IDLE;
      loadReg    <= '0;
      prescaler  <= '0;
    end else begin
      curState   <= nextState;
      savedState <= nextSaved;
      loadReg    <= nextLoad;
      prescaler  <= nextPrescaler;
    end
  end

  // Load outranks run; both buttons are ignored during the single LOAD cycle.
  always_comb begin
    nextState     = curState;
    nextSaved     = savedState;
    nextLoad      = loadReg;
    nextPrescaler = prescaler;
    if (curState == RUN) begin
      nextPrescaler = (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
    end
    case (curState)
      LOAD: nextState = savedState;
      default: begin
        if (loadEvt) begin
          nextState     = LOAD;
          nextSaved     = curState;
          nextLoad      = sw;
          nextPrescaler = '0;
        end else if (runEvt) begin
          nextState = (curState == RUN) ? PAUSE : RUN;
        end
      end
    endcase
  end

  assign state     = curState;
  assign running   = (curState == RUN);
  assign cnt_load  = (curState == LOAD);
  assign cnt_en    = (curState == RUN) && (prescaler == PRE_LAST);
  assign load_data = loadReg;
endmodule

// File: tb/tb_lab1_count_ctrl.sv
// Directed scenarios followed by random button activity, all scored against a history-based reference model.
module tb_lab1_count_ctrl;
  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 2;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LOAD = 3;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       load_n   = 1'b1;
  logic       run_n    = 1'b1;
  logic [9:0] sw       = '0;
  logic       cnt_en, cnt_load, running;
  logic [9:0] load_data;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int loadPulses = 0;
  int runCycles = 0;

  lab1_count_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .load_n    (load_n),
    .run_n     (run_n),
    .sw        (sw),
    .cnt_en    (cnt_en),
    .cnt_load  (cnt_load),
    .load_data (load_data),
    .running   (running),
    .state     (state)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Reference model: raw button samples kept as a history; an event needs DEB_CYCLES
  // equal levels that are already two samples old (synchronizer delay).
  int         mState, mSaved, mRunCyc;
  logic [9:0] mLoadData;
  bit         mLoadEvt, mRunEvt, mLoadRel, mRunRel;
  bit         histLd[$];
  bit         histRn[$];

  function automatic bit windowAll(input bit q[$], input bit v);
    if (q.size() < DEB_CYCLES + 2) return 1'b0;
    for (int i = q.size() - 2 - DEB_CYCLES; i < q.size() - 2; i++)
      if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelStep(input bit rst, input bit ldRaw, input bit rnRaw, input logic [9:0] swv);
    bit newLd, newRn;
    if (rst) begin
      mState = S_IDLE; mSaved = S_IDLE; mRunCyc = 0; mLoadData = '0;
      mLoadEvt = 1'b0; mRunEvt = 1'b0; mLoadRel = 1'b1; mRunRel = 1'b1;
      histLd.delete(); histLd.push_back(1'b1); histLd.push_back(1'b1);
      histRn.delete(); histRn.push_back(1'b1); histRn.push_back(1'b1);
    end else begin
      if (mState == S_RUN) mRunCyc++;
      if (mLoadEvt && mState != S_LOAD) begin
        mSaved = mState; mState = S_LOAD; mLoadData = swv; mRunCyc = 0;
      end else if (mState == S_LOAD) begin
        mState = mSaved;
      end else if (mRunEvt) begin
        mState = (mState == S_RUN) ? S_PAUSE : S_RUN;
      end
      histLd.push_back(ldRaw);
      if (histLd.size() > DEB_CYCLES + 2) void'(histLd.pop_front());
      histRn.push_back(rnRaw);
      if (histRn.size() > DEB_CYCLES + 2) void'(histRn.pop_front());
      newLd = mLoadRel && windowAll(histLd, 1'b0);
      newRn = mRunRel && windowAll(histRn, 1'b0);
      if (windowAll(histLd, !mLoadRel)) mLoadRel = !mLoadRel;
      if (windowAll(histRn, !mRunRel)) mRunRel = !mRunRel;
      mLoadEvt = newLd;
      mRunEvt  = newRn;
    end
  endtask

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutputs();
    check("state", 10'(state), 10'(mState));
    check("cnt_load", 10'(cnt_load), 10'(mState == S_LOAD));
    check("running", 10'(running), 10'(mState == S_RUN));
    check("cnt_en", 10'(cnt_en), 10'(mState == S_RUN && (mRunCyc % TICK_DIV) == TICK_DIV - 1));
    check("load_data", load_data, mLoadData);
    check("en_load_excl", 10'(cnt_en & cnt_load), 10'd0);
    if (cnt_load === 1'b1) loadPulses++;
    if (running === 1'b1) runCycles++;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLOCK_50);
      modelStep(reset, load_n, run_n, sw);
      @(negedge CLOCK_50);
      checkOutputs();
    end
  endtask

  initial begin
    bit hit;
    reset = 1'b1; tick(3);
    reset = 1'b0; tick(20);
    check("idle_state", 10'(state), 10'd0);

    run_n = 1'b0; tick(4);
    check("run_entry_early", 10'(state), 10'd0);
    tick(1);
    check("run_entry", 10'(state), 10'd1);
    tick(5); run_n = 1'b1; tick(20);

    run_n = 1'b0; tick(10); run_n = 1'b1; tick(12);
    check("pause_state", 10'(state), 10'd2);
    run_n = 1'b0; tick(10); run_n = 1'b1; tick(10);
    check("resume_state", 10'(state), 10'd1);

    sw = 10'b0101010101; loadPulses = 0;
    load_n = 1'b0; tick(10); load_n = 1'b1; tick(10);
    check("load_pulse_count", 10'(loadPulses), 10'd1);
    check("load_value", load_data, 10'h155);
    check("load_return_run", 10'(state), 10'd1);

    reset = 1'b1; tick(2); reset = 1'b0;
    loadPulses = 0; runCycles = 0;
    load_n = 1'b0; run_n = 1'b0; tick(10);
    load_n = 1'b1; run_n = 1'b1; tick(10);
    check("both_load_count", 10'(loadPulses), 10'd1);
    check("both_no_run", 10'(runCycles), 10'd0);
    check("both_idle", 10'(state), 10'd0);
    run_n = 1'b0; tick(1); run_n = 1'b1; tick(10);
    check("glitch_idle", 10'(state), 10'd0);

    sw = 10'h2aa; load_n = 1'b0; hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick(1);
      if (mState == S_LOAD) hit = 1'b1;
    end
    check("load_reached", 10'(hit), 10'd1);
    reset = 1'b1; tick(1); reset = 1'b0;
    check("reset_in_load_state", 10'(state), 10'd0);
    check("reset_in_load_data", load_data, 10'd0);
    check("reset_in_load_strobe", 10'(cnt_load), 10'd0);
    load_n = 1'b1; tick(8);

    run_n = 1'b0; reset = 1'b1; tick(3); reset = 1'b0;
    tick(4);
    check("held_after_reset_early", 10'(state), 10'd0);
    tick(1);
    check("held_after_reset_run", 10'(state), 10'd1);
    run_n = 1'b1; tick(8);

    for (int seg = 0; seg < 300; seg++) begin
      reset  = ($urandom_range(0, 39) == 0);
      load_n = ($urandom_range(0, 3) != 0);
      run_n  = ($urandom_range(0, 2) != 0);
      sw     = 10'($urandom);
      tick($urandom_range(1, 8));
    end
    reset = 1'b0; load_n = 1'b1; run_n = 1'b1; tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
